// File: rtl/pipeline_ctrl_unit_if.sv
// pipeline_ctrl_unit_if: hazard/cache status in, per-latch enable/flush controls out.
// master drives status (HDU/caches side); slave is the control unit.
`default_nettype none

interface pipeline_ctrl_unit_if;
  logic freeze;
  logic threeInstrFlush;
  logic ihit;
  logic dmemREN;
  logic dmemWEN;
  logic dhit;
  logic wb_halt;
  logic pc_en;
  logic ifid_en;
  logic idex_en;
  logic exmem_en;
  logic memwb_en;
  logic ifid_flush;
  logic idex_flush;
  logic exmem_flush;
  logic halt;
  logic flush_pend;

  modport master (
    output freeze, threeInstrFlush, ihit, dmemREN, dmemWEN, dhit, wb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush, halt, flush_pend
  );

  modport slave (
    input  freeze, threeInstrFlush, ihit, dmemREN, dmemWEN, dhit, wb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, halt, flush_pend
  );
endinterface

`default_nettype wire

// File: rtl/pipeline_ctrl_unit.sv
// pipeline_ctrl_unit: latch enable/flush sequencing with pending-flush slot and sticky halt.
// PIPE_PERF_CNT_EN adds saturating freeze/flush/dstall counters. Rev 1.0
`default_nettype none

module pipeline_ctrl_unit #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_ctrl_unit_if.slave  ctl
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     freeze_cnt_o,
  output logic [CNT_W-1:0]     flush_cnt_o,
  output logic [CNT_W-1:0]     dstall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic dwait, advance, active, flush_req;
  logic flush_apply, freeze_apply;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush;

  assign dwait     = (ctl.dmemREN | ctl.dmemWEN) & ~ctl.dhit;
  assign advance   = ctl.ihit & ~dwait;
  assign active    = ~rst & (state_q != HALTED);
  assign flush_req = ctl.threeInstrFlush | (state_q == PEND);

  always_comb begin
    state_d      = state_q;
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    flush_apply  = 1'b0;
    freeze_apply = 1'b0;
    if (active) begin
      if (dwait) begin
        // full stall: everything already held at 0
      end else if (!ctl.ihit) begin
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        if (ctl.freeze) begin
          idex_flush = 1'b1;
        end else begin
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
        end
      end else if (flush_req) begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        flush_apply = 1'b1;
      end else if (ctl.freeze) begin
        idex_en      = 1'b1;
        idex_flush   = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        freeze_apply = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end

      // A flush that cannot advance parks in the single PEND slot.
      if (ctl.wb_halt && !dwait) begin
        state_d = HALTED;
      end else if (flush_apply) begin
        state_d = RUN;
      end else if (ctl.threeInstrFlush) begin
        state_d = PEND;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign ctl.pc_en       = pc_en;
  assign ctl.ifid_en     = ifid_en;
  assign ctl.idex_en     = idex_en;
  assign ctl.exmem_en    = exmem_en;
  assign ctl.memwb_en    = memwb_en;
  assign ctl.ifid_flush  = ifid_flush;
  assign ctl.idex_flush  = idex_flush;
  assign ctl.exmem_flush = exmem_flush;
  assign ctl.halt        = (state_q == HALTED);
  assign ctl.flush_pend  = (state_q == PEND);

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] freeze_cnt_q, flush_cnt_q, dstall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      freeze_cnt_q <= '0;
      flush_cnt_q  <= '0;
      dstall_cnt_q <= '0;
    end else begin
      if (freeze_apply && (freeze_cnt_q != '1)) freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
      if (flush_apply && (flush_cnt_q != '1))   flush_cnt_q  <= flush_cnt_q + CNT_W'(1);
      if (active && dwait && (dstall_cnt_q != '1)) dstall_cnt_q <= dstall_cnt_q + CNT_W'(1);
    end
  end

  assign freeze_cnt_o = freeze_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
  assign dstall_cnt_o = dstall_cnt_q;
`else
  if (CNT_W > 0) begin : g_no_perf_cnt
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl_unit.sv
// Scoreboard bench for pipeline_ctrl_unit: directed vectors push expected control vectors,
// a negedge monitor pops and compares against the DUT outputs.
`default_nettype none

module tb_pipeline_ctrl_unit;
  localparam int CNT_W = 32;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, halt, flush_pend}
  localparam logic [9:0] E_ZERO   = 10'b00000_000_00;
  localparam logic [9:0] E_RUN    = 10'b11111_000_00;
  localparam logic [9:0] E_FREEZE = 10'b00111_010_00;
  localparam logic [9:0] E_FLUSH  = 10'b11111_111_00;
  localparam logic [9:0] E_BUBBLE = 10'b01111_100_00;
  localparam logic [9:0] E_PSTALL = 10'b00000_000_01;
  localparam logic [9:0] E_HALT   = 10'b00000_000_10;

  typedef struct {
    int         idx;
    logic [9:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;
  sb_t  sbq[$];

  pipeline_ctrl_unit_if bus ();

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] freeze_cnt, flush_cnt, dstall_cnt;
`endif

  pipeline_ctrl_unit #(.CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus.slave)
`ifdef PIPE_PERF_CNT_EN
    ,
    .freeze_cnt_o (freeze_cnt),
    .flush_cnt_o  (flush_cnt),
    .dstall_cnt_o (dstall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic frz, input logic tif, input logic ih,
                      input logic ren, input logic wen, input logic dh, input logic wbh,
                      input logic [9:0] exp);
    sb_t e;
    @(posedge clk);
    #1;
    rst                 = r;
    bus.freeze          = frz;
    bus.threeInstrFlush = tif;
    bus.ihit            = ih;
    bus.dmemREN         = ren;
    bus.dmemWEN         = wen;
    bus.dhit            = dh;
    bus.wb_halt         = wbh;
    step_no++;
    e.idx = step_no;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  initial begin : monitor
    sb_t        e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e   = sbq.pop_front();
        act = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
               bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.halt, bus.flush_pend};
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL ctl_vec step=%0d actual=%b required=%b", e.idx, act, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout steps=%0d", step_no);
    $fatal(1, "timeout");
  end

`ifdef PIPE_PERF_CNT_EN
  task automatic check_cnt(input string name, input logic [CNT_W-1:0] act,
                           input logic [CNT_W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
`endif

  initial begin : stim
    bus.freeze = 0; bus.threeInstrFlush = 0; bus.ihit = 1; bus.dmemREN = 0;
    bus.dmemWEN = 0; bus.dhit = 0; bus.wb_halt = 0;

    //    rst frz tif ih ren wen dh wbh  expected
    step(1, 0, 0, 1, 0, 0, 0, 0, E_ZERO);
    step(1, 0, 0, 1, 0, 0, 0, 0, E_ZERO);
    step(0, 0, 0, 1, 0, 0, 0, 0, E_RUN);
    step(0, 1, 0, 1, 0, 0, 0, 0, E_FREEZE);
    step(0, 0, 0, 0, 0, 0, 0, 0, E_BUBBLE);
    step(0, 1, 0, 0, 0, 0, 0, 0, E_FREEZE);
    // load miss with branch flush parked until dhit
    step(0, 0, 1, 1, 1, 0, 0, 0, E_ZERO);
    step(0, 0, 0, 1, 1, 0, 0, 0, E_PSTALL);
    step(0, 0, 0, 1, 1, 0, 0, 0, E_PSTALL);
    step(0, 0, 0, 1, 1, 0, 1, 0, E_FLUSH | 10'b00000_000_01);
    step(0, 0, 0, 1, 0, 0, 0, 0, E_RUN);
    // flush during icache miss, repeated request while pending, applied once
    step(0, 0, 1, 0, 0, 0, 0, 0, E_BUBBLE);
    step(0, 0, 1, 0, 0, 0, 0, 0, E_BUBBLE | 10'b00000_000_01);
    step(0, 0, 1, 1, 0, 0, 0, 0, E_FLUSH | 10'b00000_000_01);
    step(0, 0, 0, 1, 0, 0, 0, 0, E_RUN);
    // store miss then hit
    step(0, 0, 0, 1, 0, 1, 0, 0, E_ZERO);
    step(0, 0, 0, 1, 0, 1, 1, 0, E_RUN);
    // flush beats freeze
    step(0, 1, 1, 1, 0, 0, 0, 0, E_FLUSH);
    step(0, 0, 0, 1, 0, 0, 0, 0, E_RUN);
    // halt blocked by dwait
    step(0, 0, 0, 1, 1, 0, 0, 1, E_ZERO);
    step(0, 0, 0, 1, 0, 0, 0, 0, E_RUN);
    // reset while pending discards the flush
    step(0, 0, 1, 1, 1, 0, 0, 0, E_ZERO);
    step(1, 0, 0, 1, 0, 0, 0, 0, E_PSTALL);
    step(0, 0, 0, 1, 0, 0, 0, 0, E_RUN);
    // sticky halt
    step(0, 0, 0, 1, 0, 0, 0, 1, E_RUN);
    for (int i = 0; i < 10; i++) begin
      step(0, i[0], i[1], 1, 0, 0, 1, 0, E_HALT);
    end
    step(1, 0, 0, 1, 0, 0, 0, 0, E_HALT);
    step(0, 0, 0, 1, 0, 0, 0, 0, E_RUN);

`ifdef PIPE_PERF_CNT_EN
    step(1, 0, 0, 1, 0, 0, 0, 0, E_ZERO);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0, 0, 0, 0, E_FREEZE);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 1, 0, 0, 0, 0, E_FLUSH);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, 0, 0, 0, E_ZERO);
    step(0, 0, 0, 1, 0, 0, 0, 0, E_RUN);
    @(negedge clk);
    check_cnt("freeze_cnt", freeze_cnt, CNT_W'(4));
    check_cnt("flush_cnt",  flush_cnt,  CNT_W'(2));
    check_cnt("dstall_cnt", dstall_cnt, CNT_W'(5));
    force u_dut.freeze_cnt_q = '1;
    force u_dut.flush_cnt_q  = '1;
    force u_dut.dstall_cnt_q = '1;
    #1;
    release u_dut.freeze_cnt_q;
    release u_dut.flush_cnt_q;
    release u_dut.dstall_cnt_q;
    step(0, 1, 0, 1, 0, 0, 0, 0, E_FREEZE);
    step(0, 0, 1, 1, 0, 0, 0, 0, E_FLUSH);
    step(0, 0, 0, 1, 1, 0, 0, 0, E_ZERO);
    step(0, 0, 0, 1, 0, 0, 0, 0, E_RUN);
    @(negedge clk);
    check_cnt("freeze_cnt_sat", freeze_cnt, '1);
    check_cnt("flush_cnt_sat",  flush_cnt,  '1);
    check_cnt("dstall_cnt_sat", dstall_cnt, '1);
`endif

    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
